// File: rtl/sargantana_icache_mshr_if.sv
// Interface bundle for the Sargantana icache MSHR: miss allocation, iFill request/response,
// array fill write-back and status.
interface sargantana_icache_mshr_if #(
  parameter int N_ENTRIES = 4,
  parameter int LINE_W    = 26,
  parameter int WAY_W     = 2,
  parameter int ID_W      = $clog2(N_ENTRIES)
);
  logic              kill_i;
  logic              alloc_valid_i;
  logic [LINE_W-1:0] alloc_paddr_i;
  logic [WAY_W-1:0]  alloc_way_i;
  logic              alloc_ready_o;
  logic              alloc_merge_o;
  logic [ID_W-1:0]   alloc_id_o;
  logic              ifill_req_valid_o;
  logic              ifill_req_ready_i;
  logic [LINE_W-1:0] ifill_req_paddr_o;
  logic [ID_W-1:0]   ifill_req_id_o;
  logic              ifill_resp_valid_i;
  logic [ID_W-1:0]   ifill_resp_id_i;
  logic              fill_valid_o;
  logic [LINE_W-1:0] fill_paddr_o;
  logic [WAY_W-1:0]  fill_way_o;
  logic [ID_W-1:0]   fill_id_o;
  logic              fill_discard_o;
  logic [ID_W:0]     occupancy_o;
  logic              proto_err_o;

  modport slave (
    input  kill_i, alloc_valid_i, alloc_paddr_i, alloc_way_i,
           ifill_req_ready_i, ifill_resp_valid_i, ifill_resp_id_i,
    output alloc_ready_o, alloc_merge_o, alloc_id_o,
           ifill_req_valid_o, ifill_req_paddr_o, ifill_req_id_o,
           fill_valid_o, fill_paddr_o, fill_way_o, fill_id_o, fill_discard_o,
           occupancy_o, proto_err_o
  );

  modport master (
    output kill_i, alloc_valid_i, alloc_paddr_i, alloc_way_i,
           ifill_req_ready_i, ifill_resp_valid_i, ifill_resp_id_i,
    input  alloc_ready_o, alloc_merge_o, alloc_id_o,
           ifill_req_valid_o, ifill_req_paddr_o, ifill_req_id_o,
           fill_valid_o, fill_paddr_o, fill_way_o, fill_id_o, fill_discard_o,
           occupancy_o, proto_err_o
  );
endinterface

// File: rtl/sargantana_icache_mshr.sv
// N-entry MSHR file tracking concurrent icache line refills by ID.
// Same-line merging is enabled by defining SARGANTANA_ICACHE_MSHR_MERGE_EN.
module sargantana_icache_mshr #(
  parameter int N_ENTRIES = 4,
  parameter int LINE_W    = 26,
  parameter int WAY_W     = 2,
  parameter int ID_W      = $clog2(N_ENTRIES)
) (
  input logic clk_i,
  input logic rst_i,
  sargantana_icache_mshr_if.slave bus
);
  // state  | meaning
  // FREE   | entry unused
  // PEND   | allocated, waiting for (or sitting in) the issue register
  // ISSUED | request accepted upstream, waiting for response
  typedef enum logic [1:0] {FREE = 2'd0, PEND = 2'd1, ISSUED = 2'd2} state_e;

  state_e            state_q [N_ENTRIES];
  state_e            state_d [N_ENTRIES];
  logic [LINE_W-1:0] paddr_q [N_ENTRIES];
  logic [LINE_W-1:0] paddr_d [N_ENTRIES];
  logic [WAY_W-1:0]  way_q   [N_ENTRIES];
  logic [WAY_W-1:0]  way_d   [N_ENTRIES];
  logic [N_ENTRIES-1:0] killed_q, killed_d;

  logic              req_valid_q, req_valid_d;
  logic [LINE_W-1:0] req_paddr_q, req_paddr_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;

  logic              fill_valid_q, fill_valid_d;
  logic [LINE_W-1:0] fill_paddr_q, fill_paddr_d;
  logic [WAY_W-1:0]  fill_way_q, fill_way_d;
  logic [ID_W-1:0]   fill_id_q, fill_id_d;
  logic              fill_discard_q, fill_discard_d;
  logic              perr_q, perr_d;

  logic            free_found, match_found, cand_found;
  logic [ID_W-1:0] free_idx, match_idx, cand_idx, scan_idx;
  logic            alloc_ready, alloc_merge, alloc_new, handshake;
  logic [ID_W:0]   occ;

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    occ         = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = ID_W'(i);
      end else begin
        occ = occ + (ID_W+1)'(1);
        if (!killed_q[i] && paddr_q[i] == bus.alloc_paddr_i) begin
          match_found = 1'b1;
          match_idx   = ID_W'(i);
        end
      end
    end
  end

`ifdef SARGANTANA_ICACHE_MSHR_MERGE_EN
  assign alloc_ready = !bus.kill_i && (free_found || match_found);
  assign alloc_merge = bus.alloc_valid_i && alloc_ready && match_found;
  assign bus.alloc_id_o = match_found ? match_idx : free_idx;
`else
  assign alloc_ready = !bus.kill_i && free_found && !match_found;
  assign alloc_merge = 1'b0;
  assign bus.alloc_id_o = free_idx;
`endif
  assign alloc_new = bus.alloc_valid_i && alloc_ready && !alloc_merge;
  assign handshake = req_valid_q && bus.ifill_req_ready_i;

  // Round-robin pick of a live PEND entry; the one already held in the issue register is skipped.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int k = N_ENTRIES - 1; k >= 0; k--) begin
      scan_idx = rr_q + ID_W'(k);
      if (state_q[scan_idx] == PEND && !killed_q[scan_idx] &&
          !(req_valid_q && req_id_q == scan_idx)) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    paddr_d        = paddr_q;
    way_d          = way_q;
    killed_d       = killed_q;
    req_valid_d    = req_valid_q;
    req_paddr_d    = req_paddr_q;
    req_id_d       = req_id_q;
    rr_d           = rr_q;
    fill_valid_d   = 1'b0;
    fill_paddr_d   = fill_paddr_q;
    fill_way_d     = fill_way_q;
    fill_id_d      = fill_id_q;
    fill_discard_d = fill_discard_q;
    perr_d         = perr_q;

    for (int i = 0; i < N_ENTRIES; i++) begin
      if (bus.kill_i && state_q[i] != FREE) killed_d[i] = 1'b1;
      if (state_q[i] == PEND && killed_q[i] && !(req_valid_q && req_id_q == ID_W'(i)))
        state_d[i] = FREE;
    end

    if (handshake) begin
      state_d[req_id_q] = ISSUED;
      req_valid_d       = 1'b0;
    end

    if (bus.ifill_resp_valid_i) begin
      if (state_q[bus.ifill_resp_id_i] == ISSUED) begin
        state_d[bus.ifill_resp_id_i] = FREE;
        fill_valid_d   = 1'b1;
        fill_paddr_d   = paddr_q[bus.ifill_resp_id_i];
        fill_way_d     = way_q[bus.ifill_resp_id_i];
        fill_id_d      = bus.ifill_resp_id_i;
        fill_discard_d = killed_q[bus.ifill_resp_id_i];
      end else begin
        perr_d = 1'b1;
      end
    end

    if (alloc_new) begin
      state_d[free_idx]  = PEND;
      paddr_d[free_idx]  = bus.alloc_paddr_i;
      way_d[free_idx]    = bus.alloc_way_i;
      killed_d[free_idx] = 1'b0;
    end

    // A fresh allocation bypasses straight into an idle issue register when nothing older waits.
    if ((!req_valid_q || bus.ifill_req_ready_i) && !bus.kill_i) begin
      if (cand_found) begin
        req_valid_d = 1'b1;
        req_paddr_d = paddr_q[cand_idx];
        req_id_d    = cand_idx;
        rr_d        = cand_idx + ID_W'(1);
      end else if (alloc_new) begin
        req_valid_d = 1'b1;
        req_paddr_d = bus.alloc_paddr_i;
        req_id_d    = free_idx;
        rr_d        = free_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= FREE;
        paddr_q[i] <= '0;
        way_q[i]   <= '0;
      end
      killed_q       <= '0;
      req_valid_q    <= 1'b0;
      req_paddr_q    <= '0;
      req_id_q       <= '0;
      rr_q           <= '0;
      fill_valid_q   <= 1'b0;
      fill_paddr_q   <= '0;
      fill_way_q     <= '0;
      fill_id_q      <= '0;
      fill_discard_q <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      paddr_q        <= paddr_d;
      way_q          <= way_d;
      killed_q       <= killed_d;
      req_valid_q    <= req_valid_d;
      req_paddr_q    <= req_paddr_d;
      req_id_q       <= req_id_d;
      rr_q           <= rr_d;
      fill_valid_q   <= fill_valid_d;
      fill_paddr_q   <= fill_paddr_d;
      fill_way_q     <= fill_way_d;
      fill_id_q      <= fill_id_d;
      fill_discard_q <= fill_discard_d;
      perr_q         <= perr_d;
    end
  end

  assign bus.alloc_ready_o     = alloc_ready;
  assign bus.alloc_merge_o     = alloc_merge;
  assign bus.ifill_req_valid_o = req_valid_q;
  assign bus.ifill_req_paddr_o = req_paddr_q;
  assign bus.ifill_req_id_o    = req_id_q;
  assign bus.fill_valid_o      = fill_valid_q;
  assign bus.fill_paddr_o      = fill_paddr_q;
  assign bus.fill_way_o        = fill_way_q;
  assign bus.fill_id_o         = fill_id_q;
  assign bus.fill_discard_o    = fill_discard_q;
  assign bus.occupancy_o       = occ;
  assign bus.proto_err_o       = perr_q;
endmodule
